// File: rtl/iter_divider.sv
// Multi-cycle 32-bit radix-2 restoring divider returning {quotient, remainder}.
// Optional build macro DIV_EARLY_TERM_EN: skip iteration when |dividend| < |divisor|.
module iter_divider #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [31:0] bmag_reg, bmag_next;
  logic [31:0] quo_reg, quo_next;
  logic [32:0] rem_reg, rem_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic        sign_q_reg, sign_q_next;
  logic        sign_r_reg, sign_r_next;
  logic [63:0] dout_reg, dout_next;
  logic        dout_valid_reg, dout_valid_next;

  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift, diff;
  logic        early;
  logic [31:0] quo_fix, rem_fix;

  assign s_axis_dividend_tready = (state_reg == IDLE);
  assign s_axis_divisor_tready  = (state_reg == IDLE);
  assign m_axis_dout_tdata      = dout_reg;
  assign m_axis_dout_tvalid     = dout_valid_reg;

  assign accept = s_axis_dividend_tvalid && s_axis_divisor_tvalid && (state_reg == IDLE);

  assign a_neg = SIGNED && a_reg[31];
  assign b_neg = SIGNED && b_reg[31];
  assign a_mag = a_neg ? (~a_reg + 32'd1) : a_reg;
  assign b_mag = b_neg ? (~b_reg + 32'd1) : b_reg;

  // One restoring step: bring in the next dividend bit, trial-subtract the divisor.
  assign rem_shift = {rem_reg[31:0], quo_reg[31]};
  assign diff      = rem_shift - {1'b0, bmag_reg};

`ifdef DIV_EARLY_TERM_EN
  assign early = (b_reg != 32'd0) && (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    bmag_next       = bmag_reg;
    quo_next        = quo_reg;
    rem_next        = rem_reg;
    cnt_next        = cnt_reg;
    sign_q_next     = sign_q_reg;
    sign_r_next     = sign_r_reg;
    dout_next       = dout_reg;
    dout_valid_next = 1'b0;
    quo_fix         = 32'd0;
    rem_fix         = 32'd0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          a_next     = s_axis_dividend_tdata;
          b_next     = s_axis_divisor_tdata;
          state_next = PREP;
        end
      end
      PREP: begin
        bmag_next   = b_mag;
        sign_q_next = a_neg ^ b_neg;
        sign_r_next = a_neg;
        cnt_next    = 5'd31;
        if (early) begin
          // Quotient is zero and the whole magnitude is the remainder.
          quo_next   = 32'd0;
          rem_next   = {1'b0, a_mag};
          state_next = DONE;
        end else begin
          quo_next   = a_mag;
          rem_next   = 33'd0;
          state_next = CALC;
        end
      end
      CALC: begin
        if (diff[32]) begin
          rem_next = rem_shift;
        end else begin
          rem_next = diff;
        end
        quo_next = {quo_reg[30:0], ~diff[32]};
        if (cnt_reg == 5'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The result register is loaded on the edge entering DONE so data and strobe align.
    if (state_next == DONE) begin
      dout_valid_next = 1'b1;
      quo_fix = sign_q_next ? (~quo_next + 32'd1) : quo_next;
      rem_fix = sign_r_next ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
      if (b_reg == 32'd0) begin
        dout_next = {32'hFFFF_FFFF, a_reg};
      end else begin
        dout_next = {quo_fix, rem_fix};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
      bmag_reg       <= 32'd0;
      quo_reg        <= 32'd0;
      rem_reg        <= 33'd0;
      cnt_reg        <= 5'd0;
      sign_q_reg     <= 1'b0;
      sign_r_reg     <= 1'b0;
      dout_reg       <= 64'd0;
      dout_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      bmag_reg       <= bmag_next;
      quo_reg        <= quo_next;
      rem_reg        <= rem_next;
      cnt_reg        <= cnt_next;
      sign_q_reg     <= sign_q_next;
      sign_r_reg     <= sign_r_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: a signed and an unsigned instance share one request stream
// and are checked against an arithmetic reference model.
module tb_iter_divider;

`ifdef DIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dvd, dvs;
  logic        dvd_v, dvs_v;
  logic        rdy_a [2];
  logic        rdy_b [2];
  logic [63:0] dout  [2];
  logic        dval  [2];

  int checks = 0;
  int errors = 0;
  logic [63:0] prev [2];

  always #5 clk = ~clk;

  // Instance 0 is signed, instance 1 is unsigned.
  iter_divider #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tdata(dvd), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(rdy_a[0]),
    .s_axis_divisor_tdata(dvs), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(rdy_b[0]),
    .m_axis_dout_tdata(dout[0]), .m_axis_dout_tvalid(dval[0])
  );

  iter_divider #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tdata(dvd), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(rdy_a[1]),
    .s_axis_divisor_tdata(dvs), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(rdy_b[1]),
    .m_axis_dout_tdata(dout[1]), .m_axis_dout_tvalid(dval[1])
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint ma, mb;
    if (sgn) begin
      ma = $signed(a);
      mb = $signed(b);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end else begin
      ma = longint'({32'd0, a});
      mb = longint'({32'd0, b});
    end
    if (EARLY && b != 32'd0 && ma < mb) return 2;
    return 34;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string name);
    logic [63:0] exp_v [2];
    logic [63:0] got   [2];
    int lat [2], seen [2], cyc [2], bad_rdy [2], bad_hold [2];
    for (int d = 0; d < 2; d++) begin
      exp_v[d] = model(a, b, d == 0);
      lat[d] = model_lat(a, b, d == 0);
      seen[d] = 0; cyc[d] = -1; bad_rdy[d] = 0; bad_hold[d] = 0; got[d] = 64'd0;
    end
    @(negedge clk);
    checks++;
    if (rdy_a[0] !== 1'b1 || rdy_b[0] !== 1'b1 || rdy_a[1] !== 1'b1 || rdy_b[1] !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %b%b%b%b, want 1111", name, rdy_a[0], rdy_b[0], rdy_a[1], rdy_b[1]);
    end
    dvd = a; dvs = b; dvd_v = 1'b1; dvs_v = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (dval[d] === 1'b1) begin
          seen[d]++; cyc[d] = c; got[d] = dout[d];
        end else if (c < lat[d] && dout[d] !== prev[d]) begin
          bad_hold[d]++;
        end
        if (c > lat[d] && dout[d] !== exp_v[d]) bad_hold[d]++;
        if (rdy_a[d] !== (c > lat[d]) || rdy_b[d] !== (c > lat[d])) bad_rdy[d]++;
      end
      if (c == 1) begin
        // Operands must be ignored once taken.
        dvd_v = 1'b0; dvs_v = 1'b0; dvd = $urandom; dvs = $urandom;
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (seen[d] != 1 || cyc[d] != lat[d]) begin
        errors++;
        $display("FAIL %s strobe[%0d]: got %0d pulses last at cycle %0d, want 1 at cycle %0d", name, d, seen[d], cyc[d], lat[d]);
      end
      checks++;
      if (got[d] !== exp_v[d]) begin
        errors++;
        $display("FAIL %s data[%0d]: got %h, want %h", name, d, got[d], exp_v[d]);
      end
      checks++;
      if (bad_rdy[d] != 0) begin
        errors++;
        $display("FAIL %s tready[%0d]: got %0d wrong cycles, want 0", name, d, bad_rdy[d]);
      end
      checks++;
      if (bad_hold[d] != 0) begin
        errors++;
        $display("FAIL %s hold[%0d]: got %0d wrong cycles, want 0", name, d, bad_hold[d]);
      end
      prev[d] = exp_v[d];
    end
    $display("op %-10s a=%h b=%h signed=%h unsigned=%h", name, a, b, got[0], got[1]);
  endtask

  task automatic test_reset();
    reset = 1'b1; dvd = 32'd50; dvs = 32'd5; dvd_v = 1'b1; dvs_v = 1'b1;
    prev[0] = 64'd0; prev[1] = 64'd0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dval[d] !== 1'b0 || dout[d] !== 64'd0 || rdy_a[d] !== 1'b1 || rdy_b[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state[%0d]: got v=%b d=%h r=%b%b, want v=0 d=0 r=11", d, dval[d], dout[d], rdy_a[d], rdy_b[d]);
      end
    end
    dvd_v = 1'b0; dvs_v = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dout[d] !== 64'd0 || rdy_a[d] !== 1'b1) begin
        errors++;
        $display("FAIL post_reset[%0d]: got d=%h r=%b, want d=0 r=1", d, dout[d], rdy_a[d]);
      end
    end
    $display("op reset     outputs idle");
  endtask

  task automatic test_directed();
    run_op(32'd7, 32'd2, "7/2");
    run_op(32'hFFFF_FFF9, 32'd2, "-7/2");
    run_op(32'd7, 32'hFFFF_FFFE, "7/-2");
    run_op(32'h1234_5678, 32'd0, "div0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, "overflow");
    run_op(32'd5, 32'd9, "5/9");
    run_op(32'd9, 32'd5, "9/5");
    run_op(32'hFFFF_FFFD, 32'd5, "-3/5");
  endtask

  task automatic test_handshake();
    int bad = 0;
    @(negedge clk);
    dvd = 32'd77; dvs = 32'd3;
    dvd_v = 1'b1; dvs_v = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (rdy_a[d] !== 1'b1 || dval[d] !== 1'b0) bad++;
    end
    dvd_v = 1'b0; dvs_v = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (rdy_b[d] !== 1'b1 || dval[d] !== 1'b0) bad++;
    end
    dvs_v = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lone_valid: got %0d accepted-looking cycles, want 0", bad);
    end
    $display("op lone_valid ignored, bad=%0d", bad);
    run_op(32'd77, 32'd3, "after_lone");
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1 [2];
    logic [63:0] r2 [2];
    int strobes [2], bad_data [2], bad_rdy [2];
    logic exp_rdy;
    for (int d = 0; d < 2; d++) begin
      r1[d] = model(32'd1000, 32'd7, d == 0);
      r2[d] = model(32'd12345, 32'd100, d == 0);
      strobes[d] = 0; bad_data[d] = 0; bad_rdy[d] = 0;
    end
    @(negedge clk);
    dvd = 32'd1000; dvs = 32'd7; dvd_v = 1'b1; dvs_v = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      exp_rdy = (c == 35) || (c >= 70);
      for (int d = 0; d < 2; d++) begin
        if (dval[d] === 1'b1) begin
          if (c == 34 || c == 69) strobes[d]++;
          else strobes[d] += 100;
        end
        if (c < 34 && dout[d] !== prev[d]) bad_data[d]++;
        if (c >= 34 && c < 69 && dout[d] !== r1[d]) bad_data[d]++;
        if (c >= 69 && dout[d] !== r2[d]) bad_data[d]++;
        if (rdy_a[d] !== exp_rdy || rdy_b[d] !== exp_rdy) bad_rdy[d]++;
      end
      if (c == 1) begin
        dvd = 32'd12345; dvs = 32'd100;
      end
      if (c == 36) begin
        dvd_v = 1'b0; dvs_v = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (strobes[d] != 2) begin
        errors++;
        $display("FAIL b2b_strobe[%0d]: got score %0d, want 2 (cycles 34 and 69)", d, strobes[d]);
      end
      checks++;
      if (bad_data[d] != 0 || bad_rdy[d] != 0) begin
        errors++;
        $display("FAIL b2b_timeline[%0d]: got %0d data / %0d tready errors, want 0", d, bad_data[d], bad_rdy[d]);
      end
      prev[d] = r2[d];
    end
    $display("op back2back signed=%h unsigned=%h", dout[0], dout[1]);
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge clk);
    dvd = 32'd1000; dvs = 32'd7; dvd_v = 1'b1; dvs_v = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (dval[d] !== 1'b0) pulses++;
      if (c == 1) begin
        dvd_v = 1'b0; dvs_v = 1'b0;
      end
      if (c == 10) reset = 1'b1;
      if (c == 14) reset = 1'b0;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_strobe: got %0d strobe cycles, want 0", pulses);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dout[d] !== 64'd0 || rdy_a[d] !== 1'b1 || rdy_b[d] !== 1'b1) begin
        errors++;
        $display("FAIL abort_state[%0d]: got d=%h r=%b%b, want d=0 r=11", d, dout[d], rdy_a[d], rdy_b[d]);
      end
      prev[d] = 64'd0;
    end
    $display("op abort     pulses=%0d", pulses);
    run_op(32'd100, 32'd10, "100/10");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = $urandom_range(0, 40);
        2: a = -$urandom_range(1, 40);
        default: a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'd0};
      endcase
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0;
        3: b = -$urandom_range(1, 15);
        default: b = $urandom_range(16, 100);
      endcase
      run_op(a, b, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    dvd = 32'd0; dvs = 32'd0; dvd_v = 1'b0; dvs_v = 1'b0; reset = 1'b1;
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
